// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Groups the control inputs and fetch-address outputs of pc_sequencer.
//   master : the controller side that drives start/stall/branch/halt and
//            observes pc, pc_valid, state, trap and fetch_count.
//   slave  : the sequencer side.
//   clk and reset stay as plain ports on the sequencer.
interface pc_sequencer_if;
    logic        start;
    logic        stall;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        halt_req;
    logic [31:0] pc;
    logic        pc_valid;
    logic [1:0]  state;
    logic        trap;
    logic [15:0] fetch_count;

    modport master (
        output start, stall, branch_valid, branch_target, halt_req,
        input  pc, pc_valid, state, trap, fetch_count
    );

    modport slave (
        input  start, stall, branch_valid, branch_target, halt_req,
        output pc, pc_valid, state, trap, fetch_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter sequencer with IDLE / RUN / HALTED / TRAP states.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset (wins over everything)
//     bus    pc_sequencer_if.slave
//              in : start, stall, branch_valid, branch_target[31:0], halt_req
//              out: pc[31:0], pc_valid, state[1:0], trap, fetch_count[15:0]
//   Parameters:
//     RESET_VECTOR  pc value loaded at reset
//     WRAP_ON_OVF   1: pc wraps to 0 past the top of the space, 0: trap

// Adds 4 to a 32-bit address; overflow is the carry out of bit 31.
module inc4_32 (
    input  logic [31:0] a,
    output logic [31:0] s,
    output logic        overflow
);
    assign {overflow, s} = {1'b0, a} + 33'd4;
endmodule

module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter bit          WRAP_ON_OVF  = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10,
        ST_TRAP   = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pc_valid_q;
    logic        trap_q;
    logic        cnt_inc;

    logic [31:0] pc_inc;
    logic        pc_ovf;

    inc4_32 u_inc (
        .a        (pc_q),
        .s        (pc_inc),
        .overflow (pc_ovf)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_RUN;
            end
            ST_RUN: begin
                // One action per cycle: halt > branch > stall > increment.
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                end else if (bus.branch_valid) begin
                    if (bus.branch_target[1:0] == 2'b00) begin
                        pc_d    = bus.branch_target;
                        cnt_inc = 1'b1;
                    end else begin
                        state_d = ST_TRAP;   // misaligned redirect, pc keeps pre-branch value
                    end
                end else if (!bus.stall) begin
                    if (pc_ovf) begin
                        if (WRAP_ON_OVF) begin
                            pc_d    = 32'h0;
                            cnt_inc = 1'b1;
                        end else begin
                            state_d = ST_TRAP;
                        end
                    end else begin
                        // A misaligned pc (from the reset vector) just keeps stepping by 4.
                        pc_d    = pc_inc;
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                if (bus.start) state_d = ST_RUN;
            end
            default: begin
                // TRAP holds everything until reset.
                state_d = ST_TRAP;
            end
        endcase
    end

    assign cnt_d = (cnt_inc && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            cnt_q      <= 16'h0;
            pc_valid_q <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            // Flags are registered from the next state so they line up with state_q.
            pc_valid_q <= (state_d == ST_RUN);
            trap_q     <= (state_d == ST_TRAP);
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_valid    = pc_valid_q;
    assign bus.state       = state_q;
    assign bus.trap        = trap_q;
    assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Directed scenarios plus randomized traffic on the default-parameter
//   sequencer, checked every cycle against a behavioural model. Three extra
//   instances cover the end-of-space trap, the wrap option and a misaligned
//   reset vector.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_sequencer_if bus();
    pc_sequencer_if bus_t();
    pc_sequencer_if bus_w();
    pc_sequencer_if bus_m();

    pc_sequencer #(.RESET_VECTOR(32'h0), .WRAP_ON_OVF(1'b0)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8), .WRAP_ON_OVF(1'b0)) dut_t (
        .clk(clk), .reset(reset), .bus(bus_t.slave));
    pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8), .WRAP_ON_OVF(1'b1)) dut_w (
        .clk(clk), .reset(reset), .bus(bus_w.slave));
    pc_sequencer #(.RESET_VECTOR(32'h0000_0002), .WRAP_ON_OVF(1'b0)) dut_m (
        .clk(clk), .reset(reset), .bus(bus_m.slave));

    int n_chk = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 run, 2 halted, 3 trap.
    int          m_mode;
    logic [31:0] m_pc;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic sl, input logic bv,
                         input logic [31:0] tgt, input logic hr);
        bus.start         = st;
        bus.stall         = sl;
        bus.branch_valid  = bv;
        bus.branch_target = tgt;
        bus.halt_req      = hr;
    endtask

    task automatic aux_start(input logic st);
        bus_t.start = st; bus_w.start = st; bus_m.start = st;
    endtask

    task automatic fetched();
        if (m_cnt < 65535) m_cnt++;
    endtask

    // Applies the rules for one rising edge using the inputs now on the bus.
    task automatic model_edge();
        longint nxt;
        if (reset) begin
            m_mode = 0; m_pc = 32'h0; m_cnt = 0;
        end else if (m_mode == 0 || m_mode == 2) begin
            if (bus.start) m_mode = 1;
        end else if (m_mode == 1) begin
            if (bus.halt_req) m_mode = 2;
            else if (bus.branch_valid) begin
                if (bus.branch_target % 4 == 0) begin
                    m_pc = bus.branch_target;
                    fetched();
                end else m_mode = 3;
            end else if (!bus.stall) begin
                nxt = longint'(m_pc) + 4;
                if (nxt > 64'h0000_0000_FFFF_FFFF) m_mode = 3;
                else begin
                    m_pc = 32'(nxt);
                    fetched();
                end
            end
        end
    endtask

    task automatic check_model();
        chk("pc", bus.pc, m_pc);
        chk("state", 32'(bus.state), 32'(m_mode));
        chk("pc_valid", 32'(bus.pc_valid), 32'(m_mode == 1));
        chk("trap", 32'(bus.trap), 32'(m_mode == 3));
        chk("fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        m_mode = 0; m_pc = 32'h0; m_cnt = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        aux_start(1'b0);
        bus_t.stall = 1'b0; bus_t.branch_valid = 1'b0; bus_t.branch_target = 32'h0; bus_t.halt_req = 1'b0;
        bus_w.stall = 1'b0; bus_w.branch_valid = 1'b0; bus_w.branch_target = 32'h0; bus_w.halt_req = 1'b0;
        bus_m.stall = 1'b0; bus_m.branch_valid = 1'b0; bus_m.branch_target = 32'h0; bus_m.halt_req = 1'b0;

        // Reset state
        step();
        reset = 1'b0;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_valid", 32'(bus.pc_valid), 32'd0);
        chk("rst_t_pc", bus_t.pc, 32'hFFFF_FFF8);

        // End-of-space behaviour and misaligned reset vector
        aux_start(1'b1);
        step();
        aux_start(1'b0);
        chk("t_run_pc", bus_t.pc, 32'hFFFF_FFF8);
        chk("m_run_pc", bus_m.pc, 32'h2);
        step();
        chk("t_pc1", bus_t.pc, 32'hFFFF_FFFC);
        chk("w_pc1", bus_w.pc, 32'hFFFF_FFFC);
        chk("m_pc1", bus_m.pc, 32'h6);
        step();
        chk("t_state", 32'(bus_t.state), 32'd3);
        chk("t_trap", 32'(bus_t.trap), 32'd1);
        chk("t_pc2", bus_t.pc, 32'hFFFF_FFFC);
        chk("t_cnt", 32'(bus_t.fetch_count), 32'd1);
        chk("w_pc2", bus_w.pc, 32'h0);
        chk("w_state", 32'(bus_w.state), 32'd1);
        chk("w_cnt", 32'(bus_w.fetch_count), 32'd2);
        chk("m_pc2", bus_m.pc, 32'hA);
        chk("m_state", 32'(bus_m.state), 32'd1);

        // Start, then three increments
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("seq_pc0", bus.pc, 32'h0);
        step(); step(); step();
        chk("seq_pc", bus.pc, 32'd12);
        chk("seq_cnt", 32'(bus.fetch_count), 32'd3);
        chk("seq_valid", 32'(bus.pc_valid), 32'd1);

        // Stall two cycles at 180
        drive(1'b0, 1'b0, 1'b1, 32'd180, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        chk("stall_pc1", bus.pc, 32'd180);
        step();
        chk("stall_pc2", bus.pc, 32'd180);
        chk("stall_cnt", 32'(bus.fetch_count), 32'd4);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("unstall_pc", bus.pc, 32'd184);
        chk("unstall_cnt", 32'(bus.fetch_count), 32'd5);

        // Branch beats stall, then misaligned branch traps
        drive(1'b0, 1'b1, 1'b1, 32'h0000_1000, 1'b0);
        step();
        chk("br_pc", bus.pc, 32'h1000);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_1002, 1'b0);
        step();
        chk("mis_state", 32'(bus.state), 32'd3);
        chk("mis_trap", 32'(bus.trap), 32'd1);
        chk("mis_pc", bus.pc, 32'h1000);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("trap_abs", 32'(bus.state), 32'd3);
        chk("trap_valid", 32'(bus.pc_valid), 32'd0);

        // Reset out of TRAP
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        reset = 1'b0;
        chk("trst_pc", bus.pc, 32'h0);
        chk("trst_state", 32'(bus.state), 32'd0);
        chk("trst_trap", 32'(bus.trap), 32'd0);
        chk("trst_cnt", 32'(bus.fetch_count), 32'd0);

        // Halt beats branch; halted ignores branch; resume from held pc
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
        step();
        chk("halt_state", 32'(bus.state), 32'd2);
        chk("halt_pc", bus.pc, 32'h4);
        drive(1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
        step();
        chk("halt_ign", bus.pc, 32'h4);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("resume_state", 32'(bus.state), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("resume_pc", bus.pc, 32'h8);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            reset = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 7))
                0:       tgt = $urandom | 32'h1;
                1, 2:    tgt = 32'hFFFF_FFF0;
                default: tgt = {$urandom_range(0, 32'h3FFF), 2'b00};
            endcase
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, tgt, $urandom_range(0, 15) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
